packet_memory_reader: RTL and testbench

Drain engine for the 64x32 packet memory block. Accepts a read command (base word address, byte length) and walks the memory through its combinational read port, one word per cycle. Streams the packet out as registered 32-bit words with valid/ready handshake, start/end-of-packet flags and last-word byte enables. Sits between a processor core's packet buffer and the output queue.

---
 rtl/packet_memory_reader_pkg.sv | 31 +++
 rtl/packet_memory_reader_out_stage.sv | 55 +++++
 rtl/packet_memory_reader.sv | 171 +++++++++++++++++
 tb/tb_packet_memory_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_memory_reader_pkg.sv
// Shared definitions for the packet memory drain engine: state encoding,
// memory geometry, length limits and the last-word byte-enable encoder.
package packet_memory_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int PKT_MEM_WORDS = 64;
   localparam int MAX_BYTES     = 256;

   // Word counter must hold PKT_MEM_WORDS itself, clamped length must hold MAX_BYTES.
   localparam int CNT_W   = $clog2(PKT_MEM_WORDS) + 1;
   localparam int CLAMP_W = $clog2(MAX_BYTES) + 1;

   localparam logic [3:0] BE_ALL = 4'b1111;

   function automatic logic [3:0] beEncode(input logic [1:0] lenLsb);
      logic [3:0] be;
      case (lenLsb)
         2'd1:    be = 4'b1000;
         2'd2:    be = 4'b1100;
         2'd3:    be = 4'b1110;
         default: be = BE_ALL;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/packet_memory_reader_out_stage.sv
// Output register of the drain engine: holds one word with its framing flags
// and reloads whenever it is empty or its current word is being consumed.
module pkt_rd_out_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_sop,
   input  logic              i_eop,
   input  logic [3:0]        i_be,
   output logic              o_canLoad,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_sop,
   output logic              o_eop,
   output logic [3:0]        o_be
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_sop;
   logic              r_eop;
   logic [3:0]        r_be;

   assign o_canLoad = !r_valid || i_ready;

   // Payload only changes on a load, so a stalled word stays stable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_be    <= 4'b0000;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_sop   <= i_sop;
         r_eop   <= i_eop;
         r_be    <= i_be;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_sop   = r_sop;
   assign o_eop   = r_eop;
   assign o_be    = r_be;

endmodule

// File: rtl/packet_memory_reader.sv
// Packet memory drain engine: walks a word range of the packet memory and streams it out.
// Defining PKT_MEM_READER_STATS_EN adds packet and byte counters.
module packet_memory_reader
   import packet_memory_reader_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic [3:0]        out_be,
   output logic              done
`ifdef PKT_MEM_READER_STATS_EN
   ,
   output logic [31:0]       stat_pkts,
   output logic [31:0]       stat_bytes
`endif
);

   state_t             r_state;
   state_t             w_nextState;
   logic [ADDR_W-1:0]  r_addr;
   logic [CNT_W-1:0]   r_remain;
   logic               r_first;
   logic               r_zeroLen;
   logic [3:0]         r_lastBe;

   logic [CLAMP_W-1:0] w_clampLen;
   logic [CNT_W-1:0]   w_words;
   logic               w_accept;
   logic               w_canLoad;
   logic               w_load;
   logic               w_isLastWord;
   logic               w_flushDone;
   logic [3:0]         w_loadBe;

   // Oversized commands are cut to one full memory's worth of bytes.
   always_comb begin
      if (int'(cmd_len) > MAX_BYTES) begin
         w_clampLen = CLAMP_W'(MAX_BYTES);
      end else begin
         w_clampLen = CLAMP_W'(cmd_len);
      end
   end

   assign w_words      = CNT_W'((w_clampLen + CLAMP_W'(3)) >> 2);
   assign w_accept     = (r_state == IDLE) && cmd_valid;
   assign w_load       = (r_state == READ) && w_canLoad;
   assign w_isLastWord = (r_remain == CNT_W'(1));
   assign w_loadBe     = w_isLastWord ? r_lastBe : BE_ALL;
   assign w_flushDone  = (r_state == FLUSH) && (r_zeroLen || (out_valid && out_ready));
   assign mem_addr     = r_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A zero-length command skips READ and finishes straight out of FLUSH.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = (w_clampLen == '0) ? FLUSH : READ;
            end
         end
         READ: begin
            if (w_load && w_isLastWord) begin
               w_nextState = FLUSH;
            end
         end
         FLUSH: begin
            if (w_flushDone) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      done      = 1'b0;
      case (r_state)
         IDLE:    cmd_ready = 1'b1;
         FLUSH:   done      = w_flushDone;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr    <= '0;
         r_remain  <= '0;
         r_first   <= 1'b0;
         r_zeroLen <= 1'b0;
         r_lastBe  <= 4'b0000;
      end else if (w_accept) begin
         r_addr    <= cmd_base;
         r_remain  <= w_words;
         r_first   <= 1'b1;
         r_zeroLen <= (w_clampLen == '0);
         r_lastBe  <= beEncode(w_clampLen[1:0]);
      end else if (w_load) begin
         r_addr    <= r_addr + ADDR_W'(1);
         r_remain  <= r_remain - CNT_W'(1);
         r_first   <= 1'b0;
      end
   end

   pkt_rd_out_stage #(
      .DATA_W (32)
   ) u_outStage (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_ready   (out_ready),
      .i_data    (mem_data),
      .i_sop     (r_first),
      .i_eop     (w_isLastWord),
      .i_be      (w_loadBe),
      .o_canLoad (w_canLoad),
      .o_valid   (out_valid),
      .o_data    (out_data),
      .o_sop     (out_sop),
      .o_eop     (out_eop),
      .o_be      (out_be)
   );

`ifdef PKT_MEM_READER_STATS_EN
   logic [CLAMP_W-1:0] r_lenBytes;
   logic [31:0]        r_statPkts;
   logic [31:0]        r_statBytes;

   // Byte count uses the clamped length, so it matches what was actually streamed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lenBytes  <= '0;
         r_statPkts  <= '0;
         r_statBytes <= '0;
      end else begin
         if (w_accept) begin
            r_lenBytes <= w_clampLen;
         end
         if (w_flushDone) begin
            r_statPkts  <= r_statPkts + 32'd1;
            r_statBytes <= r_statBytes + 32'(r_lenBytes);
         end
      end
   end

   assign stat_pkts  = r_statPkts;
   assign stat_bytes = r_statBytes;
`endif

endmodule

// File: tb/tb_packet_memory_reader.sv
// Directed bench for packet_memory_reader: a behavioural 64-word memory feeds the
// read port and each step checks outputs against hand-derived values.
module tb_packet_memory_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_base;
   logic [8:0]  cmd_len;
   logic [5:0]  mem_addr;
   logic [31:0] mem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic [3:0]  out_be;
   logic        done;
`ifdef PKT_MEM_READER_STATS_EN
   logic [31:0] stat_pkts;
   logic [31:0] stat_bytes;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] memArr [64];

   always #5 clk = ~clk;

   assign mem_data = memArr[mem_addr];

   packet_memory_reader #(
      .ADDR_W (6),
      .LEN_W  (9)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_base  (cmd_base),
      .cmd_len   (cmd_len),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_be    (out_be),
      .done      (done)
`ifdef PKT_MEM_READER_STATS_EN
      ,
      .stat_pkts  (stat_pkts),
      .stat_bytes (stat_bytes)
`endif
   );

   // Each memory word encodes its own address so a wrong address shows up as wrong data.
   function automatic logic [31:0] memWord(input logic [5:0] a);
      return {8'hC0, 2'b00, a, 8'h3C, 2'b11, ~a};
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) begin
         memArr[i] = memWord(6'(i));
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Checks the word currently presented, without advancing time.
   task automatic checkWordNow(input logic [5:0] a, input logic sop, input logic eop,
                               input logic [3:0] be, input logic doneExp);
      checkOutput("outValid", 32'(out_valid), 32'd1);
      checkOutput("outData",  out_data, memWord(a));
      checkOutput("outSop",   32'(out_sop), 32'(sop));
      checkOutput("outEop",   32'(out_eop), 32'(eop));
      checkOutput("outBe",    32'(out_be), 32'(be));
      checkOutput("done",     32'(done), 32'(doneExp));
   endtask

   task automatic checkWord(input logic [5:0] base, input int i, input int n, input logic [3:0] lastBe);
      logic       isLast;
      logic [5:0] a;
      @(negedge clk);
      isLast = (i == n - 1);
      a      = base + 6'(i);
      checkWordNow(a, (i == 0), isLast, isLast ? lastBe : 4'hF, isLast);
   endtask

   task automatic checkIdleAgain();
      checkOutput("idleValid", 32'(out_valid), 32'd0);
      checkOutput("idleDone",  32'(done), 32'd0);
      checkOutput("idleReady", 32'(cmd_ready), 32'd1);
   endtask

   // Presents a command for one cycle and checks the cycle right after acceptance.
   task automatic applyStimulus(input logic [5:0] base, input logic [8:0] len);
      cmd_base  = base;
      cmd_len   = len;
      cmd_valid = 1'b1;
      checkOutput("cmdReady", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("cmdReadyBusy", 32'(cmd_ready), 32'd0);
      checkOutput("noValidYet",   32'(out_valid), 32'd0);
      if (len != 9'd0) begin
         checkOutput("memAddrBase", 32'(mem_addr), 32'(base));
      end
   endtask

   task automatic drainFullRate(input logic [5:0] base, input int n, input int first, input logic [3:0] lastBe);
      for (int i = first; i < n; i++) begin
         checkWord(base, i, n, lastBe);
      end
      @(negedge clk);
      checkIdleAgain();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_base  = 6'd0;
      cmd_len   = 9'd0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
      checkOutput("rstValid",    32'(out_valid), 32'd0);
      checkOutput("rstData",     out_data, 32'd0);
      checkOutput("rstSop",      32'(out_sop), 32'd0);
      checkOutput("rstEop",      32'(out_eop), 32'd0);
      checkOutput("rstBe",       32'(out_be), 32'd0);
      checkOutput("rstMemAddr",  32'(mem_addr), 32'd0);
      checkOutput("rstDone",     32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] two-word packet from base 0");
      applyStimulus(6'd0, 9'd8);
      drainFullRate(6'd0, 2, 0, 4'hF);

      $display("[TB] wrapping packet from base 62");
      applyStimulus(6'd62, 9'd13);
      drainFullRate(6'd62, 4, 0, 4'h8);

      $display("[TB] zero-length command");
      applyStimulus(6'd3, 9'd0);
      checkOutput("zeroDone",    32'(done), 32'd1);
      checkOutput("zeroNoValid", 32'(out_valid), 32'd0);
      @(negedge clk);
      checkIdleAgain();

`ifdef PKT_MEM_READER_STATS_EN
      checkOutput("statPkts",  stat_pkts, 32'd3);
      checkOutput("statBytes", stat_bytes, 32'd21);
`endif

      $display("[TB] backpressure on the last word");
      applyStimulus(6'd10, 9'd6);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checkWordNow(6'd10, 1'b1, 1'b0, 4'hF, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checkWordNow(6'd11, 1'b0, 1'b1, 4'hC, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checkWordNow(6'd11, 1'b0, 1'b1, 4'hC, 1'b0);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checkWordNow(6'd11, 1'b0, 1'b1, 4'hC, 1'b1);
      @(negedge clk);
      checkIdleAgain();

      $display("[TB] backpressure on the first word freezes the address");
      out_ready = 1'b0;
      applyStimulus(6'd5, 9'd12);
      @(negedge clk);
      checkWordNow(6'd5, 1'b1, 1'b0, 4'hF, 1'b0);
      checkOutput("stallAddr0", 32'(mem_addr), 32'd6);
      @(negedge clk);
      checkWordNow(6'd5, 1'b1, 1'b0, 4'hF, 1'b0);
      checkOutput("stallAddr1", 32'(mem_addr), 32'd6);
      out_ready = 1'b1;
      drainFullRate(6'd5, 3, 1, 4'hF);

      $display("[TB] oversized command clamps to 64 words");
      applyStimulus(6'd5, 9'd300);
      drainFullRate(6'd5, 64, 0, 4'hF);

      $display("[TB] reset on the third word of a ten-word packet");
      applyStimulus(6'd20, 9'd40);
      checkWord(6'd20, 0, 10, 4'hF);
      checkWord(6'd20, 1, 10, 4'hF);
      checkWord(6'd20, 2, 10, 4'hF);
      reset = 1'b1;
      #1;
      checkOutput("midRstValid",   32'(out_valid), 32'd0);
      checkOutput("midRstData",    out_data, 32'd0);
      checkOutput("midRstSop",     32'(out_sop), 32'd0);
      checkOutput("midRstEop",     32'(out_eop), 32'd0);
      checkOutput("midRstBe",      32'(out_be), 32'd0);
      checkOutput("midRstMemAddr", 32'(mem_addr), 32'd0);
      checkOutput("midRstDone",    32'(done), 32'd0);
      checkOutput("midRstReady",   32'(cmd_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkIdleAgain();
      end

      $display("[TB] fresh single-word packet after reset");
      applyStimulus(6'd30, 9'd3);
      drainFullRate(6'd30, 1, 0, 4'hE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
